// File: rtl/masked_ctrl_pkg.sv
// Shared types and defaults for the masked S-box layer controller.
package masked_ctrl_pkg;

  localparam int NIBBLES_DEF = 16;
  localparam int RND_W_DEF   = 16;
  localparam int CNT_W       = $clog2(NIBBLES_DEF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/share_nibble_mux.sv
// One share register of the state: nibble select towards the S-box and
// in-place write-back of the S-box result nibble.
module share_nibble_mux #(
  parameter int NIBBLES = 16,
  parameter int CW      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [4*NIBBLES-1:0]   load_val_i,
  input  logic                   clr_i,
  input  logic [CW-1:0]          sel_i,
  input  logic                   wr_en_i,
  input  logic [CW-1:0]          wr_idx_i,
  input  logic [3:0]             wr_nib_i,
  output logic [4*NIBBLES-1:0]   sh_o,
  output logic [3:0]             nib_o
);

  logic [4*NIBBLES-1:0] sh_q, sh_d;

  // Next share value: a fresh load wins, then clear, then nibble write-back.
  always_comb begin
    sh_d = sh_q;
    if (load_i)
      sh_d = load_val_i;
    else if (clr_i)
      sh_d = '0;
    else if (wr_en_i)
      sh_d[4*int'(wr_idx_i) +: 4] = wr_nib_i;
  end

  // Share register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign sh_o  = sh_q;
  assign nib_o = sh_q[4*int'(sel_i) +: 4];

endmodule

// File: rtl/masked_sbox_layer_ctrl.sv
// Sequences one masked S-box over all nibbles of a two-share state, one
// nibble per cycle that has fresh randomness available.
// Optional feature macro: SBOX_CTRL_ZEROIZE_EN (zero idle S-box inputs and
// clear the result shares the cycle after completion).
module masked_sbox_layer_ctrl
  import masked_ctrl_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF,
  parameter int RND_W   = RND_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 inv,
  input  logic [4*NIBBLES-1:0] x_in,
  input  logic [4*NIBBLES-1:0] y_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] x_out,
  output logic [4*NIBBLES-1:0] y_out,
  input  logic                 rnd_valid,
  input  logic [RND_W-1:0]     rnd_data,
  output logic                 rnd_ready,
  output logic [3:0]           sb_x,
  output logic [3:0]           sb_y,
  output logic [RND_W-1:0]     sb_r,
  output logic                 sb_en,
  output logic                 sb_sel,
  input  logic [3:0]           sb_zx,
  input  logic [3:0]           sb_zy
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] widx_q, widx_d;
  logic          pend_q, pend_d;
  logic          sel_q, sel_d;
  logic          load, clr;
  logic [3:0]    nx, ny;

  // Next-state, counter and handshake decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    pend_d  = 1'b0;
    sel_d   = sel_q;
    load    = 1'b0;
    clr     = 1'b0;
    sb_en   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          sel_d   = ~inv;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sb_en = rnd_valid;
        if (rnd_valid) begin
          pend_d = 1'b1;
          widx_d = cnt_q;
          // cnt parks on the last nibble instead of wrapping.
          if (cnt_q == LAST) state_d = S_DRAIN;
          else               cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
`ifdef SBOX_CTRL_ZEROIZE_EN
        clr     = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      pend_q  <= 1'b0;
      sel_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
    end
  end

  share_nibble_mux #(.NIBBLES(NIBBLES), .CW(CW)) u_xr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (x_in),
    .clr_i      (clr),
    .sel_i      (cnt_q),
    .wr_en_i    (pend_q),
    .wr_idx_i   (widx_q),
    .wr_nib_i   (sb_zx),
    .sh_o       (x_out),
    .nib_o      (nx)
  );

  share_nibble_mux #(.NIBBLES(NIBBLES), .CW(CW)) u_yr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (y_in),
    .clr_i      (clr),
    .sel_i      (cnt_q),
    .wr_en_i    (pend_q),
    .wr_idx_i   (widx_q),
    .wr_nib_i   (sb_zy),
    .sh_o       (y_out),
    .nib_o      (ny)
  );

  assign busy      = (state_q != S_IDLE);
  assign rnd_ready = sb_en;
  assign sb_sel    = sel_q;

`ifdef SBOX_CTRL_ZEROIZE_EN
  // Keep share nibbles and randomness off the S-box inputs when idle.
  assign sb_x = sb_en ? nx : 4'h0;
  assign sb_y = sb_en ? ny : 4'h0;
  assign sb_r = sb_en ? rnd_data : '0;
`else
  assign sb_x = nx;
  assign sb_y = ny;
  assign sb_r = rnd_data;
`endif

endmodule
